// File: rtl/serial_code_tx_pkg.sv
// ---------------------------------------------------------------------------
// serial_code_tx_pkg
// Shared definitions for the serial code-word transmitter: the FSM state
// encoding, the frame geometry, the line levels and a helper that maps an
// FSM state to the serial line level it drives.
// ---------------------------------------------------------------------------
package serial_code_tx_pkg;

  localparam int unsigned FRAME_BITS = 6;  // start + 3 data + parity + stop
  localparam int unsigned DATA_BITS  = 3;

  localparam logic IDLE_LEVEL  = 1'b0;
  localparam logic START_LEVEL = 1'b1;
  localparam logic STOP_LEVEL  = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Index of the data bit on the line; counts DATA_BITS-1 down to 0.
  typedef logic [1:0] idx_t;

  // Line level for a given state. Data bits go out MSB first, and the
  // parity bit makes the XOR of the three data bits plus parity zero.
  function automatic logic frame_level(input state_t                 state,
                                       input logic [DATA_BITS-1:0] code,
                                       input idx_t                 idx);
    logic level;
    case (state)
      S_START:  level = START_LEVEL;
      S_DATA:   level = code[idx];
      S_PARITY: level = ^code;
      S_STOP:   level = STOP_LEVEL;
      default:  level = IDLE_LEVEL;
    endcase
    return level;
  endfunction

endpackage

// File: rtl/serial_code_tx_bit_tick_counter.sv
// ---------------------------------------------------------------------------
// bit_tick_counter
// Counts clock cycles within one serial bit, 0..BIT_TICKS-1, and wraps to 0
// after the terminal count.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   clear     : hold the count at 0 (used while the line is idle)
//   tick_done : high in the last cycle of the current bit
// ---------------------------------------------------------------------------
module bit_tick_counter #(
  parameter int unsigned BIT_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick_done
);

  localparam logic [7:0] LAST_TICK = 8'(BIT_TICKS - 1);

  logic [7:0] r_count;

  assign tick_done = (r_count == LAST_TICK);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples its inputs from before the edge, regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear || tick_done) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 8'd1;
    end
  end

endmodule

// File: rtl/serial_code_tx.sv
// ---------------------------------------------------------------------------
// serial_code_tx
// Serializes a 3-bit code word as a 6-bit frame:
//   start(1), code[2], code[1], code[0], even parity, stop(0)
// with every bit held for BIT_TICKS cycles. The line idles at 0.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   in_valid : code word offered
//   in_code  : code word, captured on accept (in_valid & in_ready)
//   in_ready : combinational, high in IDLE while not in reset
//   sout     : registered serial line
//   busy     : frame in progress
//   done     : one-cycle pulse in the last cycle of the stop bit
// ---------------------------------------------------------------------------
module serial_code_tx
  import serial_code_tx_pkg::*;
#(
  parameter int unsigned BIT_TICKS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_code,
  output logic                 in_ready,
  output logic                 sout,
  output logic                 busy,
  output logic                 done
);

  state_t               r_state;
  logic [DATA_BITS-1:0] r_code;
  idx_t                 r_idx;
  logic                 r_sout;

  state_t               w_next_state;
  logic [DATA_BITS-1:0] w_next_code;
  idx_t                 w_next_idx;
  logic                 w_next_sout;
  logic                 w_tick_done;
  logic                 w_accept;

  // The counter sits at 0 throughout IDLE, so the start bit gets a full
  // BIT_TICKS cycles counted from the accept edge.
  bit_tick_counter #(
    .BIT_TICKS (BIT_TICKS)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .clear     (r_state == S_IDLE),
    .tick_done (w_tick_done)
  );

  assign in_ready = (r_state == S_IDLE) && !rst;
  assign w_accept = in_valid && in_ready;
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_STOP) && w_tick_done;
  assign sout     = r_sout;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_next_code  = r_code;
    w_next_idx   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = S_START;
          w_next_code  = in_code;
        end
      end
      S_START: begin
        if (w_tick_done) begin
          w_next_state = S_DATA;
          w_next_idx   = idx_t'(DATA_BITS - 1);
        end
      end
      S_DATA: begin
        if (w_tick_done) begin
          if (r_idx == '0) begin
            w_next_state = S_PARITY;
          end else begin
            w_next_idx = r_idx - idx_t'(1);
          end
        end
      end
      S_PARITY: begin
        if (w_tick_done) begin
          w_next_state = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tick_done) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    // The line level is derived from the next state so that sout can be a
    // register and still show the start bit one cycle after the accept edge.
    w_next_sout = frame_level(w_next_state, w_next_code, w_next_idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_code  <= '0;
      r_idx   <= '0;
      r_sout  <= IDLE_LEVEL;
    end else begin
      r_state <= w_next_state;
      r_code  <= w_next_code;
      r_idx   <= w_next_idx;
      r_sout  <= w_next_sout;
    end
  end

endmodule

// File: tb/tb_serial_code_tx.sv
// ---------------------------------------------------------------------------
// tb_serial_code_tx
// Scoreboard bench for serial_code_tx. Two instances run on a shared clock:
// one with BIT_TICKS=4 and one with BIT_TICKS=1. Each driver call applies
// one cycle of inputs just after a rising edge and pushes the outputs
// expected for that cycle. A monitor pops and compares them on the
// following falling edge.
// ---------------------------------------------------------------------------
module tb_serial_code_tx;
  import serial_code_tx_pkg::*;

  typedef struct packed {
    logic sout;
    logic busy;
    logic done;
    logic ready;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1 = 1'b1, valid1 = 1'b0;
  logic [2:0] code1 = 3'b000;
  logic       ready1, sout1, busy1, done1;

  logic       rst4 = 1'b1, valid4 = 1'b0;
  logic [2:0] code4 = 3'b000;
  logic       ready4, sout4, busy4, done4;

  serial_code_tx #(.BIT_TICKS(1)) u_dut1 (
    .clk      (clk),
    .rst      (rst1),
    .in_valid (valid1),
    .in_code  (code1),
    .in_ready (ready1),
    .sout     (sout1),
    .busy     (busy1),
    .done     (done1)
  );

  serial_code_tx #(.BIT_TICKS(4)) u_dut4 (
    .clk      (clk),
    .rst      (rst4),
    .in_valid (valid4),
    .in_code  (code4),
    .in_ready (ready4),
    .sout     (sout4),
    .busy     (busy4),
    .done     (done4)
  );

  exp_t q1[$];
  exp_t q4[$];
  exp_t e1, e4;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc1_n = 0;
  int   cyc4_n = 0;

  task automatic check(input string tag, input logic got, input logic want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input logic s, input logic b, input logic d,
                              input logic r);
    exp_t e;
    e.sout  = s;
    e.busy  = b;
    e.done  = d;
    e.ready = r;
    return e;
  endfunction

  // Expected outputs in cycle k (1-based, counted from the accept edge)
  // of a frame carrying code c with bt cycles per bit.
  function automatic exp_t frame_exp(input logic [2:0] c, input int k,
                                     input int bt);
    logic [FRAME_BITS-1:0] bits;
    int                    pos;
    bits = {1'b1, c[2], c[1], c[0], c[2] ^ c[1] ^ c[0], 1'b0};
    pos  = FRAME_BITS - 1 - (k - 1) / bt;
    return mk(bits[pos], 1'b1, k == FRAME_BITS * bt, 1'b0);
  endfunction

  task automatic cyc1(input logic r, input logic v, input logic [2:0] c,
                      input exp_t e);
    @(posedge clk);
    #1;
    rst1 = r; valid1 = v; code1 = c;
    q1.push_back(e);
  endtask

  task automatic cyc4(input logic r, input logic v, input logic [2:0] c,
                      input exp_t e);
    @(posedge clk);
    #1;
    rst4 = r; valid4 = v; code4 = c;
    q4.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      cyc1_n++;
      check($sformatf("bt1 c%0d sout", cyc1_n),  sout1,  e1.sout);
      check($sformatf("bt1 c%0d busy", cyc1_n),  busy1,  e1.busy);
      check($sformatf("bt1 c%0d done", cyc1_n),  done1,  e1.done);
      check($sformatf("bt1 c%0d ready", cyc1_n), ready1, e1.ready);
    end
    if (q4.size() > 0) begin
      e4 = q4.pop_front();
      cyc4_n++;
      check($sformatf("bt4 c%0d sout", cyc4_n),  sout4,  e4.sout);
      check($sformatf("bt4 c%0d busy", cyc4_n),  busy4,  e4.busy);
      check($sformatf("bt4 c%0d done", cyc4_n),  done4,  e4.done);
      check($sformatf("bt4 c%0d ready", cyc4_n), ready4, e4.ready);
    end
  end

  initial begin
    // ---- BIT_TICKS=1: reset, then 011 and 111 back to back ----
    cyc1(1'b1, 1'b0, 3'b000, mk(0, 0, 0, 0));
    cyc1(1'b1, 1'b0, 3'b000, mk(0, 0, 0, 0));
    cyc1(1'b0, 1'b1, 3'b011, mk(0, 0, 0, 1));
    for (int k = 1; k <= 6; k++)
      cyc1(1'b0, 1'b1, 3'b111, frame_exp(3'b011, k, 1));
    cyc1(1'b0, 1'b1, 3'b111, mk(0, 0, 0, 1));  // single idle cycle
    for (int k = 1; k <= 6; k++)
      cyc1(1'b0, 1'b0, 3'b000, frame_exp(3'b111, k, 1));
    cyc1(1'b0, 1'b0, 3'b000, mk(0, 0, 0, 1));

    // ---- BIT_TICKS=4: reset, then 101 ----
    cyc4(1'b1, 1'b0, 3'b000, mk(0, 0, 0, 0));
    cyc4(1'b1, 1'b0, 3'b000, mk(0, 0, 0, 0));
    cyc4(1'b0, 1'b1, 3'b101, mk(0, 0, 0, 1));
    for (int k = 1; k <= 24; k++)
      cyc4(1'b0, 1'b0, 3'b000, frame_exp(3'b101, k, 4));
    cyc4(1'b0, 1'b0, 3'b000, mk(0, 0, 0, 1));

    // ---- 001 accepted, input switched to 110 mid-frame ----
    cyc4(1'b0, 1'b1, 3'b001, mk(0, 0, 0, 1));
    cyc4(1'b0, 1'b1, 3'b001, frame_exp(3'b001, 1, 4));
    for (int k = 2; k <= 23; k++)
      cyc4(1'b0, 1'b1, 3'b110, frame_exp(3'b001, k, 4));
    cyc4(1'b0, 1'b0, 3'b110, frame_exp(3'b001, 24, 4));
    cyc4(1'b0, 1'b0, 3'b000, mk(0, 0, 0, 1));

    // ---- reset pulse in DATA (cycle 10) aborts the frame ----
    cyc4(1'b0, 1'b1, 3'b010, mk(0, 0, 0, 1));
    for (int k = 1; k <= 9; k++)
      cyc4(1'b0, 1'b0, 3'b010, frame_exp(3'b010, k, 4));
    cyc4(1'b1, 1'b0, 3'b010, frame_exp(3'b010, 10, 4));
    cyc4(1'b0, 1'b0, 3'b000, mk(0, 0, 0, 1));
    cyc4(1'b0, 1'b0, 3'b000, mk(0, 0, 0, 1));

    // ---- in_valid held through a 3-cycle reset; reset wins ----
    for (int i = 0; i < 3; i++)
      cyc4(1'b1, 1'b1, 3'b011, mk(0, 0, 0, 0));
    cyc4(1'b0, 1'b1, 3'b011, mk(0, 0, 0, 1));
    for (int k = 1; k <= 24; k++)
      cyc4(1'b0, 1'b0, 3'b000, frame_exp(3'b011, k, 4));
    cyc4(1'b0, 1'b0, 3'b000, mk(0, 0, 0, 1));

    @(negedge clk);
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_code_tx.md
SERIAL_CODE_TX -- requirements
Module: serial_code_tx

Interface
REQ-001 Parameter BIT_TICKS, default 4, SHALL set clock cycles per serial bit (legal range 1..255).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 in_valid  input  1  code word offered.
REQ-005 in_code  input  3  code word to transmit, sampled on accept.
REQ-006 in_ready  output  1  block can accept a code word.
REQ-007 sout  output  1  serial line (the bit stream a State_Diagram-style serial detector consumes on its inp).
REQ-008 busy  output  1  frame in progress.
REQ-009 done  output  1  one-cycle pulse at frame end.

Function
REQ-010 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-011 Accept SHALL occur on a clk edge where in_valid=1 and in_ready=1.
REQ-012 in_ready SHALL be combinational: 1 when state=IDLE and rst=0, else 0.
REQ-013 On accept, in_code SHALL be latched; later in_code/in_valid changes SHALL be ignored until the next IDLE.
REQ-014 Frame SHALL be: start bit (1), in_code[2], in_code[1], in_code[0], even-parity bit (XOR of the 3 data bits), stop bit (0).
REQ-015 Each frame bit SHALL hold sout for exactly BIT_TICKS cycles; total frame = 6*BIT_TICKS cycles.
REQ-016 sout SHALL show the start bit in the first cycle after the accept edge (latency 1), and SHALL be a registered output.
REQ-017 Idle line level SHALL be sout=0.
REQ-018 A bit-tick counter SHALL count 0..BIT_TICKS-1; terminal count advances to the next bit and wraps to 0.
REQ-019 A data-bit index SHALL count 2 down to 0 in DATA; at terminal count of bit 0, move to PARITY.
REQ-020 Transitions: IDLE->START on accept; START->DATA, DATA->PARITY (after bit 0), PARITY->STOP, STOP->IDLE, each at terminal count.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 done SHALL be 1 only in the last cycle of STOP; in_ready SHALL be 1 on the following cycle.
REQ-023 Back-to-back frames SHALL have exactly one IDLE cycle between the end of STOP and the next START.
REQ-024 BIT_TICKS=1 SHALL yield one cycle per bit with no lost or repeated bits.

Reset
REQ-025 rst=1 at an edge SHALL force state=IDLE, sout=0, busy=0, done=0, counters=0, latched code=0.
REQ-026 While rst=1, in_ready SHALL be 0 and no accept SHALL occur, even with in_valid=1.
REQ-027 Reset mid-frame SHALL abort the frame without a done pulse; sout=0 from the next cycle.
REQ-028 rst and in_valid both high at the same edge: reset wins.

Structure
REQ-029 A shared package SHALL hold the state encoding, FRAME_BITS=6, DATA_BITS=3, IDLE_LEVEL=0, START_LEVEL=1, STOP_LEVEL=0.
REQ-030 Sub-module bit_tick_counter (parameter BIT_TICKS; ports clk, rst, clear, tick_done) SHALL implement REQ-018.

Verification
REQ-031 BIT_TICKS=4, in_code=3'b101 accepted -> sout = 1,1,0,1,0,0 per 4-cycle bit (parity 0), done at cycle 24 after accept.
REQ-032 BIT_TICKS=1, in_code=3'b011, then 3'b111 with in_valid held high -> sout 1,0,1,1,0,0, one idle 0, then 1,1,1,1,1,0.
REQ-033 in_code changed from 3'b001 to 3'b110 two cycles after accept -> serialized data stays 0,0,1, parity 1.
REQ-034 rst pulsed in DATA cycle 10 of a BIT_TICKS=4 frame -> next cycle sout=0, busy=0, no done; in_ready=1 once rst drops.
REQ-035 in_valid=1 held while rst=1 for 3 cycles -> in_ready=0 and sout=0 throughout; accept on first edge after rst=0.
